// File: rtl/recovery_accumulator_pkg.sv
// rtl/recovery_accumulator_pkg.sv - shared defaults, FSM state type and count sizing
package recovery_accumulator_pkg;

  localparam int WIDTH_DEF     = 64;
  localparam int SIGN_W_DEF    = 16;
  localparam int MAX_TERMS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  function automatic int cnt_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(MAX_TERMS_DEF);

endpackage

// File: rtl/recovery_adder.sv
// rtl/recovery_adder.sv - approximate adder: exact low k bits, carry ORed into bit k, OR above
module recovery_adder
  import recovery_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [6:0]       k,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] exact;
  logic             carry_k;
  int               keff;

  assign exact = a + b;

  always_comb begin
    keff = int'({25'd0, k});
    if (keff > WIDTH) keff = WIDTH;
    carry_k = 1'b0;
    sum     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // exact ^ a ^ b at bit i recovers the carry that rippled into that bit
      if (i == keff) carry_k = exact[i] ^ a[i] ^ b[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i < keff)       sum[i] = exact[i];
      else if (i == keff) sum[i] = a[i] | b[i] | carry_k;
      else                sum[i] = a[i] | b[i];
    end
  end

endmodule

// File: rtl/recovery_accumulator.sv
// rtl/recovery_accumulator.sv - accumulates one-hot terms with the approximate adder and holds the result
module recovery_accumulator
  import recovery_accumulator_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SIGN_W    = SIGN_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_onehot,
  input  logic              in_last,
  input  logic [6:0]        cfg_recover,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [SIGN_W-1:0] out_sign,
  output logic              out_err,
  output logic              out_trunc
);

  localparam int CNT_W = cnt_width(MAX_TERMS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [6:0]       k_q, k_d;
  logic             err_q, err_d;
  logic             trunc_q, trunc_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] add_sum;
  logic             accept, is_onehot;

  recovery_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (acc_q),
    .b   (in_onehot),
    .k   (k_q),
    .sum (add_sum)
  );

  assign is_onehot = (|in_onehot) && ~|(in_onehot & (in_onehot - WIDTH'(1)));
  // rdy_en_q keeps in_ready low until the first edge after reset releases
  assign in_ready  = rdy_en_q && (state_q != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + ONE_C;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    err_d   = err_q;
    trunc_d = trunc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = in_onehot;
          cnt_d   = ONE_C;
          k_d     = cfg_recover;
          err_d   = !is_onehot;
          trunc_d = 1'b0;
          if (in_last) begin
            state_d = ST_HOLD;
          end else if (ONE_C == MAX_C) begin
            state_d = ST_HOLD;
            trunc_d = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          err_d = err_q | !is_onehot;
          if (in_last) begin
            state_d = ST_HOLD;
          end else if (cnt_inc == MAX_C) begin
            state_d = ST_HOLD;
            trunc_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      trunc_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      err_q    <= err_d;
      trunc_q  <= trunc_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_sign  = out_sum[WIDTH-1 -: SIGN_W];
  assign out_err   = out_valid & err_q;
  assign out_trunc = out_valid & trunc_q;

endmodule

// File: tb/tb_recovery_accumulator.sv
// tb/tb_recovery_accumulator.sv - directed self-checking bench for recovery_accumulator
module tb_recovery_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_onehot = '0;
  logic        in_last = 1'b0;
  logic [6:0]  cfg_recover = 7'd64;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic [15:0] out_sign;
  logic        out_err;
  logic        out_trunc;

  int n_tests = 0;
  int n_fail  = 0;

  recovery_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_onehot   (in_onehot),
    .in_last     (in_last),
    .cfg_recover (cfg_recover),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_sign    (out_sign),
    .out_err     (out_err),
    .out_trunc   (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one term, waits (bounded) for in_ready, returns at accept edge + 1
  task automatic send(input logic [63:0] term, input logic last);
    int waited;
    in_valid  = 1'b1;
    in_onehot = term;
    in_last   = last;
    waited    = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_onehot = '0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_sum_zero"}, out_sum, 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // exact add, 8+8+8
    cfg_recover = 7'd64;
    send(64'd8, 1'b0);
    send(64'd8, 1'b0);
    check("k64_mid_valid", 64'(out_valid), 64'd0);
    send(64'd8, 1'b1);
    check("k64_valid", 64'(out_valid), 64'd1);
    check("k64_sum", out_sum, 64'd24);
    check("k64_sign", 64'(out_sign), 64'd0);
    check("k64_err", 64'(out_err), 64'd0);
    check("k64_trunc", 64'(out_trunc), 64'd0);
    drain("k64");

    // pure OR
    cfg_recover = 7'd0;
    send(64'd8, 1'b0);
    send(64'd8, 1'b1);
    check("k0_sum", out_sum, 64'd8);
    drain("k0");

    // carry out of low 4 bits lands in bit 4
    cfg_recover = 7'd4;
    send(64'd8, 1'b0);
    send(64'd8, 1'b1);
    check("k4_sum", out_sum, 64'd16);
    drain("k4");

    // k latched at first accept: later change to 64 must not matter
    cfg_recover = 7'd0;
    send(64'd8, 1'b0);
    cfg_recover = 7'd64;
    send(64'd8, 1'b1);
    check("k_latched_sum", out_sum, 64'd8);
    drain("klatch");

    // k above WIDTH behaves as WIDTH: 2^63 + 2^63 wraps to 0
    cfg_recover = 7'd100;
    send(64'h8000_0000_0000_0000, 1'b0);
    send(64'h8000_0000_0000_0000, 1'b1);
    check("k100_wrap_sum", out_sum, 64'd0);
    drain("k100");

    // sign field and stable hold under backpressure
    cfg_recover = 7'd64;
    send(64'h8000_0000_0000_0000, 1'b0);
    send(64'h0001_0000_0000_0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_sign", 64'(out_sign), 64'h8001);
      check("hold_sum", out_sum, 64'h8001_0000_0000_0000);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    drain("hold");

    // non-one-hot term flags error
    send(64'd3, 1'b0);
    send(64'd1, 1'b1);
    check("err_flag", 64'(out_err), 64'd1);
    check("err_sum", out_sum, 64'd4);
    drain("err");

    // truncation at MAX_TERMS
    for (int t = 0; t < 32; t++) send(64'd1, 1'b0);
    check("trunc_valid", 64'(out_valid), 64'd1);
    check("trunc_sum", out_sum, 64'd32);
    check("trunc_flag", 64'(out_trunc), 64'd1);
    check("trunc_ready", 64'(in_ready), 64'd0);
    drain("trunc");

    // reset mid-run discards partial result
    send(64'd1, 1'b0);
    send(64'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_after_valid", 64'(out_valid), 64'd0);
    send(64'd4, 1'b1);
    check("midrst_new_valid", 64'(out_valid), 64'd1);
    check("midrst_new_sum", out_sum, 64'd4);
    check("midrst_new_err", 64'(out_err), 64'd0);
    drain("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/recovery_accumulator.md
RECOVERY_ACCUMULATOR -- requirements
Module: recovery_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning datapath width of one-hot terms and the sum.
REQ-002 SHALL have parameter SIGN_W, default 16, meaning width of the sign/high field taken from the top of the sum.
REQ-003 SHALL have parameter MAX_TERMS, default 32, meaning maximum number of terms per accumulation.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning an upstream term is presented.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a term this cycle.
REQ-008 SHALL have port in_onehot, input, WIDTH, meaning the term, nominally one-hot (2**y from the one-hot stage).
REQ-009 SHALL have port in_last, input, 1, meaning the final term of the current accumulation.
REQ-010 SHALL have port cfg_recover, input, 7, meaning k, the number of low bits added exactly; values above WIDTH act as WIDTH.
REQ-011 SHALL have port out_valid, output, 1, meaning a result is held.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream takes the result.
REQ-013 SHALL have port out_sum, output, WIDTH, meaning the accumulated approximate sum.
REQ-014 SHALL have port out_sign, output, SIGN_W, meaning out_sum[WIDTH-1:WIDTH-SIGN_W].
REQ-015 SHALL have port out_err, output, 1, meaning at least one accepted term was not exactly one-hot.
REQ-016 SHALL have port out_trunc, output, 1, meaning accumulation ended at MAX_TERMS without in_last.

Function
REQ-017 A term SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-018 The approximate add SHALL compute the low k bits as (acc + term) mod 2**k, OR the carry-out of that low field into bit k, and compute bits k and above as acc | term with no carry.
REQ-019 With k = WIDTH the add SHALL equal exact addition mod 2**WIDTH; with k = 0 it SHALL be plain bitwise OR.
REQ-020 The FSM SHALL have states IDLE, ACCUM, HOLD.
REQ-021 IDLE: in_ready=1; on accept, acc=term, count=1, k latched from cfg_recover, err=(term not one-hot); next state HOLD if in_last, else ACCUM.
REQ-022 ACCUM: in_ready=1; on accept, acc=approx_add(acc,term), count+1, err ORed; next state HOLD if in_last or count reaches MAX_TERMS.
REQ-023 out_trunc SHALL be set when HOLD is entered on reaching MAX_TERMS with in_last=0.
REQ-024 HOLD: in_ready=0, out_valid=1, all outputs stable; on out_ready, return to IDLE in the next cycle.
REQ-025 out_valid SHALL rise the cycle after the last term is accepted (latency 1).
REQ-026 cfg_recover changes after the first accepted term SHALL NOT affect the current accumulation.
REQ-027 out_sum, out_sign, out_err and out_trunc SHALL be 0 whenever out_valid is 0.

Reset
REQ-028 rst SHALL asynchronously force IDLE, acc=0, count=0, latched k=0, err=0, trunc=0, out_valid=0, in_ready=0 while rst=1.
REQ-029 rst asserted mid-accumulation or in HOLD SHALL discard the partial or held result with no output.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst deasserts.

Structure
REQ-031 A shared package SHALL hold WIDTH, SIGN_W, MAX_TERMS defaults, the state enum, and the count width $clog2(MAX_TERMS+1).
REQ-032 The approximate add SHALL be a combinational sub-module named recovery_adder (inputs a, b, k; output sum).

Verification
REQ-033 k=64, terms 8,8,8 (last on third) -> out_sum=24, out_sign=0, out_err=0, out_valid one cycle after the third accept.
REQ-034 k=0, terms 8,8 -> out_sum=8; k=4, terms 8,8 -> out_sum=16.
REQ-035 k=64, terms 2**63, 2**48 -> out_sign=16'h8001; out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-036 Term 3 (not one-hot), then term 1 with last -> out_err=1.
REQ-037 32 terms of 1 with in_last never asserted, k=64 -> out_sum=32, out_trunc=1.
REQ-038 rst pulsed after the 2nd of 4 terms -> no out_valid; a new 1-term run with value 4 and last -> out_sum=4.
